mem_arbiter: RTL and testbench

Arbitrates the CPU's single memory port between instruction fetch (IF), data load/store (DS) and, optionally, a debug port (DBG). It sits between the fetch/decode/execute/commit phase sequencer's requesters and the memory. It grants one requester at a time with fixed priority, drives the memory for a configurable number of wait states, and returns read data with a one-cycle ACK pulse.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_priority.sv | 20 ++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, grant bit
// positions and wait-state counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned GNT_IF  = 0;
    localparam int unsigned GNT_DS  = 1;
    localparam int unsigned GNT_DBG = 2;
    localparam int unsigned NUM_REQ = 3;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/mem_arb_priority.sv
// Fixed-priority one-hot encoder for the arbiter: DS over IF over DBG.
module mem_arb_priority
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] win
);

    always_comb begin
        win = '0;
        if (req[GNT_DS]) begin
            win[GNT_DS] = 1'b1;
        end else if (req[GNT_IF]) begin
            win[GNT_IF] = 1'b1;
        end else if (req[GNT_DBG]) begin
            win[GNT_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port arbiter for fetch, data and (with MEM_ARB_DEBUG_EN defined)
// a debug requester; fixed priority, configurable wait states, registered outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    input  logic              DS_REQ,
    input  logic              DS_WE,
    input  logic [ADDR_W-1:0] DS_ADDR,
    input  logic [DATA_W-1:0] DS_WDATA,
`ifdef MEM_ARB_DEBUG_EN
    input  logic              DBG_REQ,
    input  logic              DBG_WE,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_WDATA,
    output logic              DBG_ACK,
`endif
    output logic              IF_ACK,
    output logic              DS_ACK,
    output logic [2:0]        GNT,
    output logic              BUSY,
    output logic [DATA_W-1:0] RDATA,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_vec, win;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 we_q, we_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 if_ack_q, if_ack_d;
    logic                 ds_ack_q, ds_ack_d;
`ifdef MEM_ARB_DEBUG_EN
    logic                 dbg_ack_q, dbg_ack_d;
`endif

    always_comb begin
        req_vec          = '0;
        req_vec[GNT_IF]  = IF_REQ;
        req_vec[GNT_DS]  = DS_REQ;
`ifdef MEM_ARB_DEBUG_EN
        req_vec[GNT_DBG] = DBG_REQ;
`endif
    end

    mem_arb_priority u_priority (
        .req (req_vec),
        .win (win)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        if_ack_d = 1'b0;
        ds_ack_d = 1'b0;
`ifdef MEM_ARB_DEBUG_EN
        dbg_ack_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|win) begin
                    state_d = ST_ACCESS;
                    gnt_d   = win;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    if (win[GNT_DS]) begin
                        addr_d  = DS_ADDR;
                        wdata_d = DS_WDATA;
                        we_d    = DS_WE;
                    end else if (win[GNT_IF]) begin
                        addr_d  = IF_ADDR;
                        we_d    = 1'b0;
                    end
`ifdef MEM_ARB_DEBUG_EN
                    else begin
                        addr_d  = DBG_ADDR;
                        wdata_d = DBG_WDATA;
                        we_d    = DBG_WE;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last access cycle: memory data is valid on this edge.
                    state_d  = ST_DONE;
                    rdata_d  = MEM_RDATA;
                    cs_d     = 1'b0;
                    we_d     = 1'b0;
                    if_ack_d = gnt_q[GNT_IF];
                    ds_ack_d = gnt_q[GNT_DS];
`ifdef MEM_ARB_DEBUG_EN
                    dbg_ack_d = gnt_q[GNT_DBG];
`endif
                end
            end
            ST_DONE: begin
                // No arbitration on this edge so requesters can drop REQ.
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b0;
            if_ack_q <= 1'b0;
            ds_ack_q <= 1'b0;
`ifdef MEM_ARB_DEBUG_EN
            dbg_ack_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            if_ack_q <= if_ack_d;
            ds_ack_q <= ds_ack_d;
`ifdef MEM_ARB_DEBUG_EN
            dbg_ack_q <= dbg_ack_d;
`endif
        end
    end

    assign IF_ACK    = if_ack_q;
    assign DS_ACK    = ds_ack_q;
`ifdef MEM_ARB_DEBUG_EN
    assign DBG_ACK   = dbg_ack_q;
`endif
    assign GNT       = gnt_q;
    assign BUSY      = busy_q;
    assign RDATA     = rdata_q;
    assign MEM_CS    = cs_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_STATES 1, 0, 3) share one stimulus
// stream and are checked against a transaction-timeline reference model.
module tb_mem_arbiter;

`ifdef MEM_ARB_DEBUG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        ds_req = 1'b0;
    logic        ds_we = 1'b0;
    logic [15:0] ds_addr = '0;
    logic [15:0] ds_wdata = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;

    logic        if_ack [3];
    logic        ds_ack [3];
    logic        dbg_ack [3];
    logic        busy [3];
    logic        mem_cs [3];
    logic        mem_we [3];
    logic [2:0]  gnt [3];
    logic [15:0] rdata [3];
    logic [15:0] mem_addr [3];
    logic [15:0] mem_wdata [3];
    logic [15:0] mem_rdata [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic logic [15:0] rom(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hBEEF : ((a ^ 16'hC3A5) + 16'h0101);
    endfunction

    for (genvar d = 0; d < 3; d++) begin : g_dut
        assign mem_rdata[d] = rom(mem_addr[d]);
        mem_arbiter #(
            .ADDR_W      (16),
            .DATA_W      (16),
            .WAIT_STATES ((d == 0) ? 1 : ((d == 1) ? 0 : 3))
        ) u_dut (
            .CLK       (clk),
            .RESET     (reset),
            .IF_REQ    (if_req),
            .IF_ADDR   (if_addr),
            .DS_REQ    (ds_req),
            .DS_WE     (ds_we),
            .DS_ADDR   (ds_addr),
            .DS_WDATA  (ds_wdata),
`ifdef MEM_ARB_DEBUG_EN
            .DBG_REQ   (dbg_req),
            .DBG_WE    (dbg_we),
            .DBG_ADDR  (dbg_addr),
            .DBG_WDATA (dbg_wdata),
            .DBG_ACK   (dbg_ack[d]),
`endif
            .IF_ACK    (if_ack[d]),
            .DS_ACK    (ds_ack[d]),
            .GNT       (gnt[d]),
            .BUSY      (busy[d]),
            .RDATA     (rdata[d]),
            .MEM_CS    (mem_cs[d]),
            .MEM_WE    (mem_we[d]),
            .MEM_ADDR  (mem_addr[d]),
            .MEM_WDATA (mem_wdata[d]),
            .MEM_RDATA (mem_rdata[d])
        );
`ifndef MEM_ARB_DEBUG_EN
        assign dbg_ack[d] = 1'b0;
`endif
    end

    // Reference model: each transaction is a record (owner, start edge e0);
    // CS covers edges e0..e0+W, ACK follows, next grant no earlier than e0+W+3.
    int          cyc = 0;
    bit          act [3];
    int          e0 [3];
    int          free_at [3];
    int          own [3];
    logic [15:0] m_addr [3];
    logic [15:0] m_wdata [3];
    bit          m_we [3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                act[d]     = 1'b0;
                free_at[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 3; d++) begin
                if (act[d] && cyc == e0[d] + ws_of(d) + 2) act[d] = 1'b0;
                if (!act[d] && cyc >= free_at[d] && (ds_req || if_req || (DBG_EN && dbg_req))) begin
                    act[d]     = 1'b1;
                    e0[d]      = cyc;
                    free_at[d] = cyc + ws_of(d) + 3;
                    if (ds_req) begin
                        own[d] = 1; m_addr[d] = ds_addr; m_we[d] = ds_we; m_wdata[d] = ds_wdata;
                    end else if (if_req) begin
                        own[d] = 0; m_addr[d] = if_addr; m_we[d] = 1'b0;
                    end else begin
                        own[d] = 2; m_addr[d] = dbg_addr; m_we[d] = dbg_we; m_wdata[d] = dbg_wdata;
                    end
                end
            end
        end
    end

    int          cs_cnt [3];
    int          ifa_cnt [3];
    int          dsa_cnt [3];
    int          dbga_cnt [3];
    logic [15:0] ack_rdata [3];
    int          ifa_cyc [$];

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin
            cs_cnt[d] = 0; ifa_cnt[d] = 0; dsa_cnt[d] = 0; dbga_cnt[d] = 0;
            ack_rdata[d] = '0;
        end
        ifa_cyc.delete();
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int       rel;
            int       w;
            bit       ecs;
            bit       eack;
            logic [2:0] eg;
            rel  = cyc - e0[d];
            w    = ws_of(d);
            ecs  = act[d] && (rel <= w);
            eack = act[d] && (rel == w + 1);
            eg   = act[d] ? 3'(1 << own[d]) : 3'b000;
            chk("gnt", d, 32'(gnt[d]), 32'(eg));
            chk("busy", d, 32'(busy[d]), 32'(act[d]));
            chk("mem_cs", d, 32'(mem_cs[d]), 32'(ecs));
            chk("mem_we", d, 32'(mem_we[d]), 32'(ecs && m_we[d]));
            chk("if_ack", d, 32'(if_ack[d]), 32'(eack && own[d] == 0));
            chk("ds_ack", d, 32'(ds_ack[d]), 32'(eack && own[d] == 1));
            chk("dbg_ack", d, 32'(dbg_ack[d]), 32'(eack && own[d] == 2));
            if (ecs) chk("mem_addr", d, 32'(mem_addr[d]), 32'(m_addr[d]));
            if (ecs && m_we[d]) chk("mem_wdata", d, 32'(mem_wdata[d]), 32'(m_wdata[d]));
            if (eack && !m_we[d]) chk("rdata", d, 32'(rdata[d]), 32'(rom(m_addr[d])));
            if (mem_cs[d] === 1'b1) cs_cnt[d]++;
            if (if_ack[d] === 1'b1) begin
                ifa_cnt[d]++;
                ack_rdata[d] = rdata[d];
                if (d == 1) ifa_cyc.push_back(cyc);
            end
            if (ds_ack[d] === 1'b1) dsa_cnt[d]++;
            if (dbg_ack[d] === 1'b1) dbga_cnt[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int s0;
        clear_counts();

        // Reset values
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdata", d, 32'(rdata[d]), 32'h0);
            chk("rst_mem_addr", d, 32'(mem_addr[d]), 32'h0);
            chk("rst_mem_wdata", d, 32'(mem_wdata[d]), 32'h0);
        end
        reset = 1'b0;
        tick();

        // Single fetch
        clear_counts();
        if_req = 1'b1; if_addr = 16'h0100;
        tick();
        if_req = 1'b0; if_addr = 16'hFFFF;
        repeat (8) tick();
        for (int d = 0; d < 3; d++) begin
            chk("fetch_cs_cycles", d, 32'(cs_cnt[d]), 32'(ws_of(d) + 1));
            chk("fetch_acks", d, 32'(ifa_cnt[d]), 32'd1);
            chk("fetch_rdata", d, 32'(ack_rdata[d]), 32'hBEEF);
        end

        // Simultaneous IF and DS: DS first, IF at the earliest following arbitration
        ds_req = 1'b1; ds_we = 1'b1; ds_addr = 16'h2000; ds_wdata = 16'h1234;
        if_req = 1'b1; if_addr = 16'h0300;
        tick();
        s0 = cyc;
        chk("sim_ds_first", 0, 32'(gnt[0]), 32'b010);
        chk("sim_ds_we", 0, 32'(mem_we[0]), 32'd1);
        chk("sim_ds_wdata", 0, 32'(mem_wdata[0]), 32'h1234);
        ds_req = 1'b0; ds_we = 1'b0;
        repeat (2) tick();
        chk("sim_ds_ack", 0, 32'(ds_ack[0]), 32'd1);
        tick();
        chk("sim_gap", 0, 32'(gnt[0]), 32'b000);
        tick();
        chk("sim_if_next", 0, 32'(gnt[0]), 32'b001);
        chk("sim_if_edge", 0, 32'(cyc - s0), 32'd4);
        repeat (2) tick();
        if_req = 1'b0;
        repeat (10) tick();

        // WAIT_STATES=0 back-to-back fetches
        clear_counts();
        if_req = 1'b1; if_addr = 16'h0042;
        repeat (7) tick();
        if_req = 1'b0;
        repeat (10) tick();
        chk("b2b_acks", 1, 32'(ifa_cnt[1]), 32'd3);
        chk("b2b_cs", 1, 32'(cs_cnt[1]), 32'd3);
        chk("b2b_ack_list", 1, 32'(ifa_cyc.size()), 32'd3);
        if (ifa_cyc.size() == 3) begin
            chk("b2b_space1", 1, 32'(ifa_cyc[1] - ifa_cyc[0]), 32'd3);
            chk("b2b_space2", 1, 32'(ifa_cyc[2] - ifa_cyc[1]), 32'd3);
        end

        // Requester address changes after grant
        ds_req = 1'b1; ds_we = 1'b0; ds_addr = 16'h0010;
        tick();
        ds_req = 1'b0;
        tick();
        ds_addr = 16'h0020;
        repeat (2) tick();
        chk("hold_cs", 2, 32'(mem_cs[2]), 32'd1);
        chk("hold_addr", 2, 32'(mem_addr[2]), 32'h0010);
        repeat (8) tick();

        // Reset during the first access cycle
        clear_counts();
        ds_req = 1'b1; ds_we = 1'b1; ds_addr = 16'h0400; ds_wdata = 16'h5555;
        tick();
        chk("pre_rst_cs", 2, 32'(mem_cs[2]), 32'd1);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_mid_cs", d, 32'(mem_cs[d]), 32'd0);
            chk("rst_mid_gnt", d, 32'(gnt[d]), 32'd0);
            chk("rst_mid_busy", d, 32'(busy[d]), 32'd0);
        end
        tick();
        reset = 1'b0;
        tick();
        chk("rearb_gnt", 2, 32'(gnt[2]), 32'b010);
        chk("rearb_no_ack", 2, 32'(dsa_cnt[2]), 32'd0);
        ds_req = 1'b0; ds_we = 1'b0;
        repeat (8) tick();
        chk("rearb_one_ack", 2, 32'(dsa_cnt[2]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if_req    = ($urandom_range(0, 99) < 40);
            ds_req    = ($urandom_range(0, 99) < 30);
            ds_we     = $urandom_range(0, 1) == 1;
            dbg_req   = ($urandom_range(0, 99) < 25);
            dbg_we    = $urandom_range(0, 1) == 1;
            if_addr   = 16'($urandom);
            ds_addr   = 16'($urandom);
            ds_wdata  = 16'($urandom);
            dbg_addr  = 16'($urandom);
            dbg_wdata = 16'($urandom);
            tick();
        end
        if_req = 1'b0; ds_req = 1'b0; dbg_req = 1'b0;
        repeat (10) tick();

`ifdef MEM_ARB_DEBUG_EN
        // Debug waits behind a continuous fetch stream, then gets served
        clear_counts();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0777;
        if_req = 1'b1; if_addr = 16'h0100;
        repeat (16) tick();
        for (int d = 0; d < 3; d++) chk("dbg_waits", d, 32'(dbga_cnt[d]), 32'd0);
        if_req = 1'b0;
        repeat (12) tick();
        dbg_req = 1'b0;
        repeat (10) tick();
        for (int d = 0; d < 3; d++) chk("dbg_served", d, 32'(dbga_cnt[d] != 0), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
